// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - operation encodings carried on req_op_i
//   - controller state enumeration
//   - DIV_ZERO_LO, the LO value returned for a skipped divide-by-zero
//     (used only when MULDIV_DIV_ZERO_SKIP_EN is defined)
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DONE  = 2'b10,
    DRAIN = 2'b11
  } md_state_e;

  // All ones, wide enough for any DATA_W up to 64; users slice the low bits.
  localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
// Pipeline-side bundle between the EX stage (master) and muldiv_ctrl (slave).
//   req_valid_i/req_op_i/req_rs_i/req_rt_i : mul/div request from EX
//   accept_i                               : EX/MEM loads HI/LO this cycle
//   flush_i                                : exception flush of EX
//   stall_o                                : EX stall request
//   result_valid_o/hi_o/lo_o               : held result
//   busy_o                                 : controller not idle
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              req_valid_i;
  logic [1:0]        req_op_i;
  logic [DATA_W-1:0] req_rs_i;
  logic [DATA_W-1:0] req_rt_i;
  logic              accept_i;
  logic              flush_i;
  logic              stall_o;
  logic              result_valid_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              busy_o;

  modport master (
    output req_valid_i, req_op_i, req_rs_i, req_rt_i, accept_i, flush_i,
    input  stall_o, result_valid_o, hi_o, lo_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_rs_i, req_rt_i, accept_i, flush_i,
    output stall_o, result_valid_o, hi_o, lo_o, busy_o
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Sequences one MULT/MULTU/DIV/DIVU at a time onto the external mul and div
// units, stalls EX until the 64-bit result is held in HI/LO, and presents it
// until EX accepts it. A flushed operation is drained, since the units cannot
// be aborted.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   ex                 : muldiv_ctrl_if.slave pipeline bundle
//   mul_start_o/div_start_o, mul_unsigned_o/div_unsigned_o : unit control
//   op1_o, op2_o       : operands to both units
//   mul_result_i/div_result_i, mul_done_i/div_done_i : unit completion
// Configuration:
//   MULDIV_DIV_ZERO_SKIP_EN : divide-by-zero bypasses the divider and
//   completes immediately with HI=rs, LO=all ones.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_ctrl_if.slave        ex,
  output logic                mul_start_o,
  output logic                mul_unsigned_o,
  output logic                div_start_o,
  output logic                div_unsigned_o,
  output logic [DATA_W-1:0]   op1_o,
  output logic [DATA_W-1:0]   op2_o,
  input  logic [2*DATA_W-1:0] mul_result_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                mul_done_i,
  input  logic                div_done_i
);

  md_state_e         state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic                isIdle;
  logic                divZero;
  logic                unitDone;
  logic [2*DATA_W-1:0] unitResult;
  logic [1:0]          curOp;
  logic                mulStart;
  logic                divStart;

  assign isIdle = (state_q == IDLE);

`ifdef MULDIV_DIV_ZERO_SKIP_EN
  assign divZero = ex.req_op_i[1] && (ex.req_rt_i == '0);
`else
  assign divZero = 1'b0;
`endif

  // Only the unit that was started is listened to; the other unit's done
  // and result are ignored for the whole operation.
  assign unitDone   = op_q[1] ? div_done_i : mul_done_i;
  assign unitResult = op_q[1] ? div_result_i : mul_result_i;

  // In IDLE the request is routed straight through so the start pulse and
  // its operands appear in the same cycle; afterwards the latched copy keeps
  // them stable even if EX changes its operand buses.
  assign curOp = isIdle ? ex.req_op_i : op_q;
  assign op1_o = isIdle ? ex.req_rs_i : a_q;
  assign op2_o = isIdle ? ex.req_rt_i : b_q;

  assign mul_start_o    = mulStart;
  assign div_start_o    = divStart;
  assign mul_unsigned_o = curOp[0];
  assign div_unsigned_o = curOp[0];

  assign ex.result_valid_o = (state_q == DONE);
  assign ex.busy_o         = !isIdle;
  assign ex.hi_o           = hi_q;
  assign ex.lo_o           = lo_q;
  assign ex.stall_o        = ex.req_valid_i && !ex.result_valid_o && !ex.flush_i;

  // State register and datapath latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state and start-pulse logic. A flush always wins: in BUSY it either
  // drains the unit or, if done arrives together with it, drops the result;
  // in DONE it discards the held result even when accept is also high.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mulStart = 1'b0;
    divStart = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex.req_valid_i && !ex.flush_i) begin
          op_d = ex.req_op_i;
          a_d  = ex.req_rs_i;
          b_d  = ex.req_rt_i;
          if (divZero) begin
            state_d = DONE;
            hi_d    = ex.req_rs_i;
            lo_d    = DIV_ZERO_LO[DATA_W-1:0];
          end else begin
            state_d = BUSY;
            if (ex.req_op_i[1]) divStart = 1'b1;
            else                mulStart = 1'b1;
          end
        end
      end
      BUSY: begin
        if (ex.flush_i) begin
          state_d = unitDone ? IDLE : DRAIN;
        end else if (unitDone) begin
          state_d = DONE;
          hi_d    = unitResult[2*DATA_W-1:DATA_W];
          lo_d    = unitResult[DATA_W-1:0];
        end
      end
      DONE: begin
        if (ex.flush_i || ex.accept_i) state_d = IDLE;
      end
      DRAIN: begin
        if (unitDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Randomised bench for muldiv_ctrl. The bench plays both the EX stage and
// the mul/div units; unit results come from plain arithmetic on the request
// operands, and the expected controller behaviour is derived cycle by cycle
// from the request/done/flush/accept timeline the bench itself generates.
// Build with MULDIV_DIV_ZERO_SKIP_EN to exercise the divide-by-zero bypass.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  muldiv_ctrl_if #(.DATA_W(W)) exIf();

  logic           mulStart, mulUns, divStart, divUns;
  logic [W-1:0]   op1, op2;
  logic [2*W-1:0] mulRes, divRes;
  logic           mulDone, divDone;

  muldiv_ctrl #(.DATA_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex             (exIf),
    .mul_start_o    (mulStart),
    .mul_unsigned_o (mulUns),
    .div_start_o    (divStart),
    .div_unsigned_o (divUns),
    .op1_o          (op1),
    .op2_o          (op2),
    .mul_result_i   (mulRes),
    .div_result_i   (divRes),
    .mul_done_i     (mulDone),
    .div_done_i     (divDone)
  );

  always #5 clk = ~clk;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [1:0]   curOp;
  logic [W-1:0] curRs, curRt;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // What a correct mul/div unit returns: {hi, lo}.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [W-1:0] rs,
                                            input logic [W-1:0] rt);
    longint       q, m;
    logic [63:0]  uq, um;
    logic [63:0]  r;
    r = '0;
    case (op)
      MD_MULT:  r = longint'($signed(rs)) * longint'($signed(rt));
      MD_MULTU: r = {32'b0, rs} * {32'b0, rt};
      MD_DIV: begin
        if (rt == 0) r = {rs, 32'hFFFFFFFF};
        else begin
          q = longint'($signed(rs)) / longint'($signed(rt));
          m = longint'($signed(rs)) % longint'($signed(rt));
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (rt == 0) r = {rs, 32'hFFFFFFFF};
        else begin
          uq = {32'b0, rs} / {32'b0, rt};
          um = {32'b0, rs} % {32'b0, rt};
          r  = {um[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic genNext();
    curOp = 2'($urandom_range(0, 3));
    curRs = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 200)) : W'($urandom);
    case ($urandom_range(0, 7))
      0:       curRt = '0;
      1, 2:    curRt = W'($urandom_range(1, 20));
      default: curRt = W'($urandom);
    endcase
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [W-1:0] rs,
                               input logic [W-1:0] rt, input logic acc, input logic fl);
    exIf.req_valid_i = valid;
    exIf.req_op_i    = op;
    exIf.req_rs_i    = rs;
    exIf.req_rt_i    = rt;
    exIf.accept_i    = acc;
    exIf.flush_i     = fl;
  endtask

  task automatic clearUnits();
    mulDone = 1'b0;
    divDone = 1'b0;
    mulRes  = {$urandom, $urandom};
    divRes  = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One operation from its start cycle. mode 0: normal; 1: flush in BUSY at
  // cycle flushAt (flushAt==lat means together with done); 2: flush together
  // with accept in DONE. hold = extra cycles spent in DONE before accept.
  task automatic runOp(input int lat, input int mode, input int flushAt, input int hold);
    logic [1:0]   op;
    logic [W-1:0] rs, rt;
    logic [63:0]  expRes;
    logic         isDiv, skip, flushNow, inDrain;
    op = curOp; rs = curRs; rt = curRt;
    isDiv  = op[1];
    expRes = refResult(op, rs, rt);
    skip   = 1'b0;
`ifdef MULDIV_DIV_ZERO_SKIP_EN
    skip = isDiv && (rt == 0);
`endif
    clearUnits();
    applyStimulus(1'b1, op, rs, rt, 1'b0, 1'b0);
    smp();
    checkOutput("start_mul", mulStart, !isDiv);
    checkOutput("start_div", divStart, isDiv && !skip);
    checkOutput("unsigned", isDiv ? divUns : mulUns, op[0]);
    checkOutput("op1_idle", op1, rs);
    checkOutput("op2_idle", op2, rt);
    checkOutput("stall_c0", exIf.stall_o, 1'b1);
    checkOutput("busy_c0", exIf.busy_o, 1'b0);
    checkOutput("rvalid_c0", exIf.result_valid_o, 1'b0);
    tick();
    if (!skip) begin
      inDrain = 1'b0;
      for (int c = 1; c <= lat; c++) begin
        clearUnits();
        flushNow = (mode == 1) && (c == flushAt);
        if (flushNow) genNext();
        if (mode == 1 && c >= flushAt)
          applyStimulus(1'b1, curOp, curRs, curRt, 1'b0, flushNow);
        else
          applyStimulus(1'b1, op, W'($urandom), W'($urandom), 1'b0, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          if (isDiv) mulDone = 1'b1;
          else       divDone = 1'b1;
        end
        if (c == lat) begin
          if (isDiv) begin divDone = 1'b1; divRes = expRes; end
          else       begin mulDone = 1'b1; mulRes = expRes; end
        end
        smp();
        checkOutput(inDrain ? "busy_drain" : "busy_run", exIf.busy_o, 1'b1);
        checkOutput("rvalid_run", exIf.result_valid_o, 1'b0);
        checkOutput("nostart_run", {mulStart, divStart}, 2'b00);
        checkOutput("stall_run", exIf.stall_o, !flushNow);
        checkOutput("op1_hold", op1, rs);
        checkOutput("op2_hold", op2, rt);
        if (flushNow) inDrain = 1'b1;
        tick();
      end
      if (mode == 1) return;
    end
    for (int h = 0; h <= hold; h++) begin
      clearUnits();
      if ($urandom_range(0, 2) == 0) begin
        mulDone = 1'b1;
        divDone = 1'($urandom_range(0, 1));
      end
      applyStimulus(1'b1, op, W'($urandom), W'($urandom), h == hold, (mode == 2) && (h == hold));
      smp();
      checkOutput("rvalid_done", exIf.result_valid_o, 1'b1);
      checkOutput("stall_done", exIf.stall_o, 1'b0);
      checkOutput("busy_done", exIf.busy_o, 1'b1);
      checkOutput("hi", exIf.hi_o, expRes[63:32]);
      checkOutput("lo", exIf.lo_o, expRes[31:0]);
      checkOutput("nostart_done", {mulStart, divStart}, 2'b00);
      tick();
    end
    genNext();
  endtask

  // Idle cycles with stray done pulses and flushes: nothing may start.
  task automatic idleCycles(input int n);
    logic [W-1:0] rs, rt;
    logic         fl;
    for (int i = 0; i < n; i++) begin
      clearUnits();
      mulDone = 1'($urandom_range(0, 1));
      divDone = 1'($urandom_range(0, 1));
      rs = W'($urandom);
      rt = W'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      applyStimulus(fl, 2'($urandom_range(0, 3)), rs, rt, 1'($urandom_range(0, 1)), fl);
      smp();
      checkOutput("busy_idle", exIf.busy_o, 1'b0);
      checkOutput("rvalid_idle", exIf.result_valid_o, 1'b0);
      checkOutput("nostart_idle", {mulStart, divStart}, 2'b00);
      checkOutput("stall_idle", exIf.stall_o, 1'b0);
      checkOutput("op1_idle_pass", op1, rs);
      tick();
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_busy"}, exIf.busy_o, 1'b0);
    checkOutput({tag, "_rvalid"}, exIf.result_valid_o, 1'b0);
    checkOutput({tag, "_stall"}, exIf.stall_o, 1'b0);
    checkOutput({tag, "_hilo"}, {exIf.hi_o, exIf.lo_o}, 64'h0);
    checkOutput({tag, "_starts"}, {mulStart, divStart, mulUns, divUns}, 4'b0);
    checkOutput({tag, "_ops"}, {op1, op2}, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    clearUnits();
    mulRes = '0;
    divRes = '0;
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    smp();
    checkZeroOutputs("reset");
    tick();
    rst = 1'b0;

    // Directed: MULT -2*3, done at cycle 4, accept straight away.
    curOp = MD_MULT; curRs = 32'hFFFFFFFE; curRt = 32'd3;
    checkOutput("ref_mult", refResult(curOp, curRs, curRt), 64'hFFFFFFFF_FFFFFFFA);
    runOp(4, 0, 0, 0);
    idleCycles(1);
    // Directed: DIVU 100/7, done at cycle 8.
    curOp = MD_DIVU; curRs = 32'd100; curRt = 32'd7;
    runOp(8, 0, 0, 1);
    // Directed: DIV flushed at cycle 2, late done at 6; pending op starts at 7.
    curOp = MD_DIV; curRs = 32'd1000; curRt = 32'd9;
    runOp(6, 1, 2, 0);
    runOp(3, 0, 0, 0);
    // Directed: done and flush together, then flush+accept together.
    curOp = MD_MULTU;
    runOp(3, 1, 3, 0);
    runOp(2, 2, 0, 0);
    idleCycles(2);
    // Directed: divide by zero.
    curOp = MD_DIV; curRs = 32'd5; curRt = 32'd0;
    runOp(3, 0, 0, 0);
    idleCycles(1);

    // Random traffic.
    genNext();
    for (int t = 0; t < 150; t++) begin
      int lat, mode;
      lat  = $urandom_range(1, 10);
      mode = ($urandom_range(0, 4) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0);
      runOp(lat, mode, $urandom_range(1, lat), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end

    // Reset in the middle of a running operation.
    curOp = MD_MULT; curRs = 32'h1234; curRt = 32'h55;
    runOp(2, 0, 0, 0);
    clearUnits();
    applyStimulus(1'b1, MD_DIV, 32'd77, 32'd3, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    clearUnits();
    mulRes = '0;
    divRes = '0;
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    smp();
    checkZeroOutputs("midreset");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multi-cycle multiply and divide units used by the EX stage. Accepts one MULT/MULTU/DIV/DIVU request at a time and drives the `mul`/`div` start/operand ports. Collects the 64-bit result, holds the EX stall until the result is ready, and presents HI/LO until the pipeline consumes them. Exception flushes are absorbed by draining the in-flight unit operation, because the units cannot be aborted.

## Interface
- `DATA_W`, 32, operand width; results are 2*DATA_W.
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid_i`  in  1  EX holds a mul/div instruction; level, held until `accept_i`
- `req_op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `req_rs_i`, `req_rt_i`  in  DATA_W  operand1 and operand2
- `accept_i`  in  1  EX/MEM register loads the result this cycle
- `flush_i`  in  1  exception flush of EX
- `stall_o`  out  1  EX stall request
- `result_valid_o`  out  1  `hi_o`/`lo_o` valid
- `hi_o`, `lo_o`  out  DATA_W  result; for mul, high/low product; for div, remainder/quotient
- `busy_o`  out  1  state is not IDLE
- `mul_start_o`, `mul_unsigned_o`  out  1  to mul unit
- `div_start_o`, `div_unsigned_o`  out  1  to div unit
- `op1_o`, `op2_o`  out  DATA_W  operands to both units
- `mul_result_i`, `div_result_i`  in  2*DATA_W  unit results, valid while the matching done is high
- `mul_done_i`, `div_done_i`  in  1  one-cycle completion pulses

## Operation
- States:
  - IDLE: no operation in flight.
  - BUSY: a unit is running.
  - DONE: the result is held for the pipeline.
  - DRAIN: a flushed operation is still running in its unit.
- IDLE:
  - `req_valid_i & ~flush_i` → pulse the `mul_start_o` or `div_start_o` selected by `req_op_i[1]` for exactly one cycle. The unsigned flag is `req_op_i[0]`.
  - Operands and op are latched into `op_q`/`a_q`/`b_q`; state goes to BUSY.
- Operand routing: `op1_o`/`op2_o` = `req_rs_i`/`req_rt_i` combinationally in IDLE, otherwise the latched `a_q`/`b_q`. Operands stay stable for the whole operation.
- BUSY:
  - Only the done signal of the started unit (`op_q[1]`) is observed; the other unit's done is ignored.
  - On that done: latch the result into `hi`/`lo` and go to DONE.
  - `flush_i` → DRAIN, or → IDLE if done arrives in the same cycle (result discarded).
- DONE:
  - `result_valid_o`=1.
  - `accept_i` → IDLE.
  - `flush_i` → IDLE with the result discarded; flush has priority over accept.
- DRAIN:
  - Wait for the started unit's done, then go to IDLE. The result is never presented.
  - New requests are stalled and not started.
- `stall_o` = `req_valid_i & ~result_valid_o & ~flush_i` (combinational).
- `accept_i` is ignored outside DONE. Done pulses in IDLE or DONE are ignored.
- Only one operation is in flight at a time; no queuing.

## Timing
- Reset: state IDLE; all outputs 0 (`stall_o` follows its equation with `result_valid_o`=0). `hi_o`/`lo_o`/`a_q`/`b_q` are 0.
- Reset mid-operation returns the controller to IDLE. The units share `rst` and reset as well.
- Request in cycle 0 → start pulse in cycle 0.
- Unit done in cycle N (N≥1) → `result_valid_o` high and `stall_o` low in cycle N+1.
- Accept in cycle N+1 → IDLE in N+2. A back-to-back request can start in N+2.
- Minimum request-to-result: 2 cycles. No combinational path from `*_done_i` to `hi_o`/`lo_o`.
- Drain after flush: IDLE one cycle after the late done. A pending request starts the cycle after that.

## Configuration
- `MULDIV_DIV_ZERO_SKIP_EN` defined:
  - DIV/DIVU with `req_rt_i`==0 does not pulse `div_start_o`. State goes IDLE→DONE directly, with `hi_o`=`req_rs_i` and `lo_o`=all ones.
  - `result_valid_o` is high in cycle 1.
- Undefined: divide-by-zero is started on the divider like any other divide, and its result is passed through unmodified.

## Structure
- Shared package `muldiv_pkg`:
  - op encoding constants (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`)
  - state enum (IDLE/BUSY/DONE/DRAIN)
  - `DIV_ZERO_LO` constant (all ones)
- No sub-module. The `mul` and `div` units are instantiated beside this block in EX and connected through the unit ports.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3, mul model done at cycle 4:
  - start pulse in cycle 0 only; `stall_o` high cycles 0–4.
  - cycle 5: `result_valid_o`=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - accept in cycle 5 → `busy_o`=0 in cycle 6.
- DIVU rs=100, rt=7, done at cycle 8:
  - hi=2, lo=14 in cycle 9.
  - `op1_o`/`op2_o` hold 100/7 through cycle 8 while `req_rs_i` is toggled.
- Flush in cycle 2 of a DIV whose done arrives at cycle 6:
  - DRAIN cycles 3–6; `result_valid_o` never asserts.
  - A new MULTU held from cycle 3 is stalled and starts in cycle 7.
- Simultaneous done and flush in BUSY → IDLE next cycle, result dropped. Flush and accept together in DONE → IDLE, result dropped.
- Spurious `mul_done_i` during a DIV, and done pulses while IDLE → no state change.
- DIV rt=0, rs=5:
  - with `MULDIV_DIV_ZERO_SKIP_EN`: no `div_start_o`; hi=5, lo=0xFFFFFFFF in cycle 1.
  - without: `div_start_o` pulses.
- `rst` asserted mid-BUSY → all outputs 0 and state IDLE next cycle.
